// File: rtl/rover_nav_pkg.sv
// Purpose : Shared definitions for the rover navigation sequencer.
//           Holds the H-bridge direction codes, the FSM state encoding
//           and the line-sensor steering decode.
// Contents: FWD / SPIN_L / SPIN_R / OFF motor codes,
//           nav_state_e (IDLE, FOLLOW, CONE_TURN, JCT_TURN, STOP),
//           nav_steer() steering map for the active-low line sensors.
package rover_nav_pkg;

  localparam logic [3:0] FWD    = 4'b0110;
  localparam logic [3:0] SPIN_L = 4'b1010;
  localparam logic [3:0] SPIN_R = 4'b0101;
  localparam logic [3:0] OFF    = 4'b0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FOLLOW    = 3'd1,
    CONE_TURN = 3'd2,
    JCT_TURN  = 3'd3,
    STOP      = 3'd4
  } nav_state_e;

  // Sensors are active low {left,mid,right}. Only the three classified
  // shapes pick a new direction; anything else keeps the previous code,
  // so feeding the result back into last_code leaves it unchanged.
  function automatic logic [3:0] nav_steer(input logic [2:0] induct,
                                           input logic [3:0] last_code);
    logic [3:0] code;
    case (induct)
      3'b101:         code = FWD;
      3'b001, 3'b011: code = SPIN_L;
      3'b100, 3'b110: code = SPIN_R;
      default:        code = last_code;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rover_nav_if.sv
// Purpose : Sensor-in / motor-out bundle of the navigation sequencer.
// Signals : run, induct[2:0], proxim, red      (sensor side, into sequencer)
//           motor_in[3:0], motor_en[1:0],
//           nav_state[2:0], cone_seen, fault   (driver side, out of sequencer)
// Modports: master - rover harness driving sensors and reading motors
//           slave  - the sequencer itself
interface rover_nav_if;
  logic       run;
  logic [2:0] induct;
  logic       proxim;
  logic       red;
  logic [3:0] motor_in;
  logic [1:0] motor_en;
  logic [2:0] nav_state;
  logic       cone_seen;
  logic       fault;

  modport master (
    output run, induct, proxim, red,
    input  motor_in, motor_en, nav_state, cone_seen, fault
  );

  modport slave (
    input  run, induct, proxim, red,
    output motor_in, motor_en, nav_state, cone_seen, fault
  );
endinterface

// File: rtl/rover_nav_debounce.sv
// Purpose : Two-flop synchronizer plus stability filter for one
//           asynchronous sensor pin.
// Ports   : clk   in  system clock
//           rst   in  synchronous active-high reset
//           din   in  raw asynchronous input
//           level out accepted (debounced) level
//           rise  out one-cycle pulse when level goes 0->1
//           fall  out one-cycle pulse when level goes 1->0
// A new level is accepted once the synchronized input has differed from
// the current level for DEBOUNCE_CYC consecutive cycles.
module rover_nav_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, count stable differing cycles, accept and pulse edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync2_r != level) begin
        if (cnt_r >= CNT_LAST) begin
          level <= sync2_r;
          rise  <= sync2_r;
          fall  <= ~sync2_r;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/rover_nav_sequencer.sv
// Purpose : Registered navigation FSM between the rover's raw sensor pins
//           and its two motor H-bridges: line following, timed 180-degree
//           cone turns, alternating branch choice at red junctions and a
//           lost-line fault stop.
// Ports   : clk  in  system clock
//           rst  in  synchronous active-high reset
//           nav  rover_nav_if.slave
//                  run, induct[2:0], proxim, red           (inputs)
//                  motor_in[3:0], motor_en[1:0], nav_state[2:0],
//                  cone_seen, fault                        (registered outputs)
// Build option: ROVER_NAV_PWM_EN - when defined, motor_en in FOLLOW is
//           gated by a free-running PWM counter (turns stay at full 11);
//           when undefined the PWM parameters are unused.
module rover_nav_sequencer
  import rover_nav_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 1000,
  parameter int TURN_MIN_CYC     = 50000,
  parameter int LOST_TIMEOUT_CYC = 2000000,
  parameter int PWM_PERIOD       = 256,
  parameter int PWM_DUTY         = 192
) (
  input logic       clk,
  input logic       rst,
  rover_nav_if.slave nav
);

  localparam int                TURN_W    = $clog2(TURN_MIN_CYC + 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_MIN_CYC);
  localparam int                LOST_W    = $clog2(LOST_TIMEOUT_CYC + 1);
  localparam logic [LOST_W-1:0] LOST_MAX  = LOST_W'(LOST_TIMEOUT_CYC);
  localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_TIMEOUT_CYC - 1);

  logic              run_s1_r;
  logic              run_s2_r;
  logic [2:0]        induct_s1_r;
  logic [2:0]        induct_s2_r;

  nav_state_e        state_r;
  logic [3:0]        motor_in_r;
  logic [1:0]        motor_en_r;
  logic              cone_seen_r;
  logic              fault_r;
  logic              dir_toggle_r;
  logic [3:0]        last_r;
  logic [TURN_W-1:0] turn_cnt_r;
  logic [LOST_W-1:0] lost_cnt_r;
  logic [LOST_W-1:0] lost_next_s;

  logic              proxim_level_s;
  logic              proxim_rise_s;
  logic              proxim_fall_s;
  logic              red_level_s;
  logic              red_rise_s;
  logic              red_fall_s;
  logic              unused_s;

  logic [3:0]        steer_s;
  logic              lost_hit_s;
  logic [1:0]        follow_en_s;

  rover_nav_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_proxim (
    .clk   (clk),
    .rst   (rst),
    .din   (nav.proxim),
    .level (proxim_level_s),
    .rise  (proxim_rise_s),
    .fall  (proxim_fall_s)
  );

  rover_nav_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_red (
    .clk   (clk),
    .rst   (rst),
    .din   (nav.red),
    .level (red_level_s),
    .rise  (red_rise_s),
    .fall  (red_fall_s)
  );

  // Only the edges of the debounced inputs drive the FSM.
  assign unused_s = ^{proxim_level_s, proxim_fall_s, red_level_s};

  // Two-flop synchronizers for run and the line sensors.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_s1_r    <= 1'b0;
      run_s2_r    <= 1'b0;
      induct_s1_r <= 3'b111;
      induct_s2_r <= 3'b111;
    end else begin
      run_s1_r    <= nav.run;
      run_s2_r    <= run_s1_r;
      induct_s1_r <= nav.induct;
      induct_s2_r <= induct_s1_r;
    end
  end

`ifdef ROVER_NAV_PWM_EN
  localparam int               PWM_W    = $clog2(PWM_PERIOD + 1);
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);
  localparam logic [PWM_W-1:0] PWM_HIGH = PWM_W'(PWM_DUTY);

  logic [PWM_W-1:0] pwm_cnt_r;

  // Free-running PWM period counter, 0..PWM_PERIOD-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_r <= '0;
    end else if (pwm_cnt_r >= PWM_LAST) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
    end
  end

  assign follow_en_s = (pwm_cnt_r < PWM_HIGH) ? 2'b11 : 2'b00;
`else
  localparam int PWM_UNUSED = PWM_PERIOD + PWM_DUTY;

  assign follow_en_s = 2'b11;
`endif

  assign steer_s    = nav_steer(induct_s2_r, last_r);
  // The cycle that would make the count reach the timeout is the fault cycle.
  assign lost_hit_s = (induct_s2_r == 3'b111) && (lost_cnt_r >= LOST_LAST);

  // Consecutive all-off-line cycles while following; saturates, never wraps.
  always_comb begin
    lost_next_s = '0;
    if ((state_r == FOLLOW) && (induct_s2_r == 3'b111)) begin
      if (lost_cnt_r != LOST_MAX) begin
        lost_next_s = lost_cnt_r + LOST_W'(1);
      end else begin
        lost_next_s = lost_cnt_r;
      end
    end else begin
      lost_next_s = '0;
    end
  end

  // Navigation FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      motor_in_r   <= OFF;
      motor_en_r   <= 2'b00;
      cone_seen_r  <= 1'b0;
      fault_r      <= 1'b0;
      dir_toggle_r <= 1'b0;
      last_r       <= FWD;
      turn_cnt_r   <= '0;
      lost_cnt_r   <= '0;
    end else if (!run_s2_r) begin
      // cone_seen and dir_toggle deliberately survive a run drop.
      state_r    <= IDLE;
      motor_in_r <= OFF;
      motor_en_r <= 2'b00;
      fault_r    <= 1'b0;
      turn_cnt_r <= '0;
      lost_cnt_r <= '0;
    end else begin
      lost_cnt_r <= lost_next_s;
      case (state_r)
        IDLE: begin
          state_r    <= FOLLOW;
          motor_in_r <= steer_s;
          last_r     <= steer_s;
          motor_en_r <= follow_en_s;
          fault_r    <= 1'b0;
        end
        FOLLOW: begin
          if (proxim_rise_s) begin
            // A coincident red edge is dropped: no toggle, no junction.
            state_r     <= CONE_TURN;
            motor_in_r  <= SPIN_L;
            motor_en_r  <= 2'b11;
            cone_seen_r <= 1'b1;
            turn_cnt_r  <= TURN_LOAD;
          end else if (red_rise_s) begin
            dir_toggle_r <= ~dir_toggle_r;
            if (cone_seen_r) begin
              // Branch side follows the freshly flipped toggle value.
              state_r    <= JCT_TURN;
              motor_in_r <= (~dir_toggle_r) ? SPIN_R : SPIN_L;
              motor_en_r <= 2'b11;
              turn_cnt_r <= TURN_LOAD;
            end else begin
              motor_in_r <= steer_s;
              last_r     <= steer_s;
              motor_en_r <= follow_en_s;
            end
          end else if (lost_hit_s) begin
            state_r    <= STOP;
            motor_in_r <= OFF;
            motor_en_r <= 2'b00;
            fault_r    <= 1'b1;
            if (red_fall_s) begin
              cone_seen_r <= 1'b0;
            end
          end else begin
            motor_in_r <= steer_s;
            last_r     <= steer_s;
            motor_en_r <= follow_en_s;
            if (red_fall_s) begin
              cone_seen_r <= 1'b0;
            end
          end
        end
        CONE_TURN, JCT_TURN: begin
          // Sensor edges are ignored during a cone turn; a junction turn
          // still honours the red falling edge.
          if ((state_r == JCT_TURN) && red_fall_s) begin
            cone_seen_r <= 1'b0;
          end
          if ((turn_cnt_r == '0) && (induct_s2_r == 3'b101)) begin
            state_r    <= FOLLOW;
            motor_in_r <= steer_s;
            last_r     <= steer_s;
            motor_en_r <= follow_en_s;
          end else if (turn_cnt_r != '0) begin
            turn_cnt_r <= turn_cnt_r - TURN_W'(1);
          end else begin
            turn_cnt_r <= '0;
          end
        end
        STOP: begin
          // Only run=0 or rst leaves STOP.
          motor_in_r <= OFF;
          motor_en_r <= 2'b00;
          fault_r    <= 1'b1;
          if (red_fall_s) begin
            cone_seen_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          motor_in_r <= OFF;
          motor_en_r <= 2'b00;
          fault_r    <= 1'b0;
        end
      endcase
    end
  end

  assign nav.motor_in  = motor_in_r;
  assign nav.motor_en  = motor_en_r;
  assign nav.nav_state = state_r;
  assign nav.cone_seen = cone_seen_r;
  assign nav.fault     = fault_r;

endmodule

// File: tb/tb_rover_nav_sequencer.sv
// Directed bench for rover_nav_sequencer (default build, PWM disabled).
// Each step drives sensors, queues the expected outputs, advances a fixed
// number of cycles and then pops and compares against the DUT.
module tb_rover_nav_sequencer;
  import rover_nav_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rover_nav_if nav_if ();

  rover_nav_sequencer #(
    .DEBOUNCE_CYC     (2),
    .TURN_MIN_CYC     (8),
    .LOST_TIMEOUT_CYC (20),
    .PWM_PERIOD       (4),
    .PWM_DUTY         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .nav (nav_if)
  );

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [3:0] mi;
    logic [1:0] me;
    logic       cs;
    logic       flt;
  } exp_t;

  exp_t sb_q[$];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_next();
    exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".state"},     {5'b0, nav_if.nav_state}, {5'b0, e.st});
      chk({e.tag, ".motor_in"},  {4'b0, nav_if.motor_in},  {4'b0, e.mi});
      chk({e.tag, ".motor_en"},  {6'b0, nav_if.motor_en},  {6'b0, e.me});
      chk({e.tag, ".cone_seen"}, {7'b0, nav_if.cone_seen}, {7'b0, e.cs});
      chk({e.tag, ".fault"},     {7'b0, nav_if.fault},     {7'b0, e.flt});
    end
  endtask

  task automatic expect_after(input int n, input string tag, input logic [2:0] st,
                              input logic [3:0] mi, input logic [1:0] me,
                              input logic cs, input logic flt);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.mi  = mi;
    e.me  = me;
    e.cs  = cs;
    e.flt = flt;
    sb_q.push_back(e);
    cyc(n);
    check_next();
  endtask

  initial begin
    rst           = 1'b1;
    nav_if.run    = 1'b0;
    nav_if.induct = 3'b111;
    nav_if.proxim = 1'b0;
    nav_if.red    = 1'b0;
    expect_after(2, "reset", IDLE, OFF, 2'b00, 1'b0, 1'b0);

    // Start: three-cycle latency from run/induct to FOLLOW + FWD.
    rst           = 1'b0;
    nav_if.run    = 1'b1;
    nav_if.induct = 3'b101;
    expect_after(2, "start_latency", IDLE,   OFF, 2'b00, 1'b0, 1'b0);
    expect_after(1, "start_follow",  FOLLOW, FWD, 2'b11, 1'b0, 1'b0);

    // Steering map and hold-last.
    nav_if.induct = 3'b110;
    expect_after(3, "steer_right", FOLLOW, SPIN_R, 2'b11, 1'b0, 1'b0);
    nav_if.induct = 3'b010;
    expect_after(3, "hold_right",  FOLLOW, SPIN_R, 2'b11, 1'b0, 1'b0);
    nav_if.induct = 3'b101;
    expect_after(3, "steer_fwd",   FOLLOW, FWD,    2'b11, 1'b0, 1'b0);
    nav_if.induct = 3'b001;
    expect_after(3, "steer_left",  FOLLOW, SPIN_L, 2'b11, 1'b0, 1'b0);

    // Lost line: 19 sightings hold, the 20th faults.
    nav_if.induct = 3'b111;
    expect_after(21, "lost_hold",  FOLLOW, SPIN_L, 2'b11, 1'b0, 1'b0);
    expect_after(1,  "lost_fault", STOP,   OFF,    2'b00, 1'b0, 1'b1);
    nav_if.run = 1'b0;
    expect_after(3, "stop_to_idle", IDLE, OFF, 2'b00, 1'b0, 1'b0);
    nav_if.run    = 1'b1;
    nav_if.induct = 3'b101;
    expect_after(3, "refollow", FOLLOW, FWD, 2'b11, 1'b0, 1'b0);

    // Cone turn with minimum spin time.
    nav_if.proxim = 1'b1;
    nav_if.induct = 3'b111;
    expect_after(4, "cone_pending", FOLLOW, FWD, 2'b11, 1'b0, 1'b0);
    nav_if.proxim = 1'b0;
    expect_after(1, "cone_enter", CONE_TURN, SPIN_L, 2'b11, 1'b1, 1'b0);
    cyc(2);
    nav_if.induct = 3'b101;
    expect_after(6, "cone_min_time", CONE_TURN, SPIN_L, 2'b11, 1'b1, 1'b0);
    expect_after(1, "cone_exit",     FOLLOW,    FWD,    2'b11, 1'b1, 1'b0);

    // Junction with cone seen: toggle 0->1 gives SPIN_R; red fall clears cone.
    nav_if.red = 1'b1;
    expect_after(5, "jct_enter", JCT_TURN, SPIN_R, 2'b11, 1'b1, 1'b0);
    nav_if.red = 1'b0;
    expect_after(5, "jct_red_fall", JCT_TURN, SPIN_R, 2'b11, 1'b0, 1'b0);
    expect_after(4, "jct_exit",     FOLLOW,   FWD,    2'b11, 1'b0, 1'b0);
    // Junction without cone: stays in FOLLOW, toggle back to 0.
    nav_if.red = 1'b1;
    expect_after(5, "red_no_cone", FOLLOW, FWD, 2'b11, 1'b0, 1'b0);
    nav_if.red = 1'b0;
    expect_after(6, "red_fall_follow", FOLLOW, FWD, 2'b11, 1'b0, 1'b0);

    // Simultaneous proxim and red edges: cone turn wins.
    nav_if.proxim = 1'b1;
    nav_if.red    = 1'b1;
    nav_if.induct = 3'b111;
    expect_after(5, "both_edges", CONE_TURN, SPIN_L, 2'b11, 1'b1, 1'b0);
    nav_if.induct = 3'b101;
    expect_after(9, "both_exit", FOLLOW, FWD, 2'b11, 1'b1, 1'b0);
    nav_if.red    = 1'b0;
    nav_if.proxim = 1'b0;
    expect_after(5, "cone_clear", FOLLOW, FWD, 2'b11, 1'b0, 1'b0);
    nav_if.proxim = 1'b1;
    expect_after(5, "cone_again",      CONE_TURN, SPIN_L, 2'b11, 1'b1, 1'b0);
    expect_after(9, "cone_again_exit", FOLLOW,    FWD,    2'b11, 1'b1, 1'b0);
    // Toggle was 0 and untouched by the combined edge, so this flips to 1.
    nav_if.red = 1'b1;
    expect_after(5, "toggle_kept", JCT_TURN, SPIN_R, 2'b11, 1'b1, 1'b0);
    expect_after(9, "jct2_exit",   FOLLOW,   FWD,    2'b11, 1'b1, 1'b0);

    // Reset in the middle of a cone turn.
    nav_if.proxim = 1'b0;
    expect_after(5, "prox_low", FOLLOW, FWD, 2'b11, 1'b1, 1'b0);
    nav_if.proxim = 1'b1;
    expect_after(5, "cone3",     CONE_TURN, SPIN_L, 2'b11, 1'b1, 1'b0);
    expect_after(2, "cone3_mid", CONE_TURN, SPIN_L, 2'b11, 1'b1, 1'b0);
    rst           = 1'b1;
    nav_if.proxim = 1'b0;
    nav_if.red    = 1'b0;
    expect_after(1, "rst_mid_turn", IDLE, OFF, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    expect_after(2, "no_resume",       IDLE,   OFF, 2'b00, 1'b0, 1'b0);
    expect_after(1, "post_rst_follow", FOLLOW, FWD, 2'b11, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
